// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants for the timing block and the pixel generator.
package vga_pkg;
    localparam int VGA_CLKS_PER_PIXEL = 4;

    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_VIS_START  = 48;
    localparam int VGA_H_VIS_END    = 688;
    localparam int VGA_H_SYNC_START = 704;

    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_VIS_START  = 33;
    localparam int VGA_V_VIS_END    = 513;
    localparam int VGA_V_SYNC_START = 523;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Half-open interval test lo <= v < hi.
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with carry-in; exposes its successor value and a carry-out.
module wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max;

    assign at_max = (count_q == MAX);

    // next_o is the value taken on the next enabled clock, so it folds in the carry.
    always_comb begin
        count_d = count_q;
        if (inc_i) count_d = at_max ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count_q <= '0;
        else if (en_i) count_q <= count_d;
    end

    assign count_o = count_q;
    assign next_o  = count_d;
    assign wrap_o  = inc_i & at_max;
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-rate divider, column/row counters, registered sync and colour.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLKS_PER_PIXEL = VGA_CLKS_PER_PIXEL,
    parameter int H_TOTAL        = VGA_H_TOTAL,
    parameter int H_VIS_START    = VGA_H_VIS_START,
    parameter int H_VIS_END      = VGA_H_VIS_END,
    parameter int H_SYNC_START   = VGA_H_SYNC_START,
    parameter int V_TOTAL        = VGA_V_TOTAL,
    parameter int V_VIS_START    = VGA_V_VIS_START,
    parameter int V_VIS_END      = VGA_V_VIS_END,
    parameter int V_SYNC_START   = VGA_V_SYNC_START
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] color_in,
    output logic       req,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic [9:0] next_col,
    output logic [9:0] next_row,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       frame_start
);
    localparam int               DIV_W   = $clog2(CLKS_PER_PIXEL);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_PIXEL - 1);

    localparam coord_t HVS = coord_t'(H_VIS_START);
    localparam coord_t HVE = coord_t'(H_VIS_END);
    localparam coord_t HSS = coord_t'(H_SYNC_START);
    localparam coord_t HT  = coord_t'(H_TOTAL);
    localparam coord_t VVS = coord_t'(V_VIS_START);
    localparam coord_t VVE = coord_t'(V_VIS_END);
    localparam coord_t VSS = coord_t'(V_SYNC_START);
    localparam coord_t VT  = coord_t'(V_TOTAL);

    logic [DIV_W-1:0] div_q, div_d;
    logic             col_wrap, row_wrap;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic [7:0]       rgb_q, rgb_d;

    assign div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    assign req   = (div_q == DIV_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    wrap_counter #(.WIDTH(COORD_W), .MODULUS(H_TOTAL)) u_col (
        .clk(clk), .rst(reset), .en_i(req), .inc_i(1'b1),
        .count_o(col), .next_o(next_col), .wrap_o(col_wrap)
    );

    wrap_counter #(.WIDTH(COORD_W), .MODULUS(V_TOTAL)) u_row (
        .clk(clk), .rst(reset), .en_i(req), .inc_i(col_wrap),
        .count_o(row), .next_o(next_row), .wrap_o(row_wrap)
    );

    assign frame_start = req & row_wrap;

    // Outputs are computed for the pixel being entered so they switch with col/row.
    always_comb begin
        hsync_d = ~in_range(next_col, HSS, HT);
        vsync_d = ~in_range(next_row, VSS, VT);
        rgb_d   = 8'h00;
        if (in_range(next_col, HVS, HVE) && in_range(next_row, VVS, VVE)) rgb_d = color_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 8'h00;
        end else if (req) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;
endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: full-size instance plus a shrunk-timing instance for frame-level checks.
module tb_vga_timing;
    localparam int C0 = 4, HT0 = 800, HVS0 = 48, HVE0 = 688, HSS0 = 704;
    localparam int VT0 = 525, VVS0 = 33, VVE0 = 513, VSS0 = 523;
    localparam int C1 = 2, HT1 = 16, HVS1 = 2, HVE1 = 12, HSS1 = 13;
    localparam int VT1 = 10, VVS1 = 2, VVE1 = 7, VSS1 = 8;

    typedef logic [51:0] vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] color_in = 8'h00;

    logic       req0, hs0, vs0, fs0, req1, hs1, vs1, fs1;
    logic [9:0] col0, row0, ncol0, nrow0, col1, row1, ncol1, nrow1;
    logic [7:0] rgb0, rgb1;
    vec_t       act0, act1;

    int         n_chk = 0, n_fail = 0;
    int         t = 0;
    logic [7:0] rgb_m0 = 8'h00, rgb_m1 = 8'h00;

    always #5 clk = ~clk;

    vga_timing u0 (
        .clk(clk), .reset(reset), .color_in(color_in), .req(req0),
        .col(col0), .row(row0), .next_col(ncol0), .next_row(nrow0),
        .hsync(hs0), .vsync(vs0), .rgb(rgb0), .frame_start(fs0)
    );

    vga_timing #(
        .CLKS_PER_PIXEL(C1), .H_TOTAL(HT1), .H_VIS_START(HVS1), .H_VIS_END(HVE1),
        .H_SYNC_START(HSS1), .V_TOTAL(VT1), .V_VIS_START(VVS1), .V_VIS_END(VVE1),
        .V_SYNC_START(VSS1)
    ) u1 (
        .clk(clk), .reset(reset), .color_in(color_in), .req(req1),
        .col(col1), .row(row1), .next_col(ncol1), .next_row(nrow1),
        .hsync(hs1), .vsync(vs1), .rgb(rgb1), .frame_start(fs1)
    );

    assign act0 = {req0, col0, row0, ncol0, nrow0, hs0, vs0, rgb0, fs0};
    assign act1 = {req1, col1, row1, ncol1, nrow1, hs1, vs1, rgb1, fs1};

    function automatic bit vis(int cc, int rr, int hvs, int hve, int vvs, int vve);
        return (cc >= hvs) && (cc < hve) && (rr >= vvs) && (rr < vve);
    endfunction

    // Expected outputs after tt clocks since reset release, from pixel index arithmetic.
    function automatic vec_t expv(int tt, int c, int ht, int vt, int hss, int vss, logic [7:0] rgbm);
        int p, cc, rr, nc, nr;
        logic rq, fs, hse, vse;
        p  = tt / c;
        cc = p % ht;
        rr = (p / ht) % vt;
        nc = (p + 1) % ht;
        nr = ((p + 1) / ht) % vt;
        rq  = (tt % c) == (c - 1);
        fs  = rq && (cc == ht - 1) && (rr == vt - 1);
        hse = (cc < hss);
        vse = (rr < vss);
        return {rq, 10'(cc), 10'(rr), 10'(nc), 10'(nr), hse, vse, rgbm, fs};
    endfunction

    // Advance one clock; the colour model latches color_in at each pixel boundary.
    task automatic tick();
        int p;
        if (t % C0 == C0 - 1) begin
            p = t / C0 + 1;
            rgb_m0 = vis(p % HT0, (p / HT0) % VT0, HVS0, HVE0, VVS0, VVE0) ? color_in : 8'h00;
        end
        if (t % C1 == C1 - 1) begin
            p = t / C1 + 1;
            rgb_m1 = vis(p % HT1, (p / HT1) % VT1, HVS1, HVE1, VVS1, VVE1) ? color_in : 8'h00;
        end
        @(posedge clk);
        t++;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        t      = 0;
        rgb_m0 = 8'h00;
        rgb_m1 = 8'h00;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        color_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({req0, col0, row0, hs0, vs0, rgb0, fs0} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut0 got req=%b col=%0d row=%0d hs=%b vs=%b rgb=%h fs=%b exp 0 0 0 1 1 00 0",
                     req0, col0, row0, hs0, vs0, rgb0, fs0);
        end
        n_chk++;
        if ({req1, col1, row1, hs1, vs1, rgb1, fs1} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut1 got req=%b col=%0d row=%0d hs=%b vs=%b rgb=%h fs=%b exp 0 0 0 1 1 00 0",
                     req1, col1, row1, hs1, vs1, rgb1, fs1);
        end
    endtask

    task automatic test_first_req();
        int first;
        color_in = 8'h00;
        release_reset();
        first = -1;
        for (int i = 0; i < 40; i++) begin
            if (req0 && first < 0) first = t + 1;
            n_chk++;
            if (act0 !== expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0)) begin
                n_fail++;
                $display("FAIL first_req t=%0d got %h exp %h", t, act0, expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0));
            end
            if (t == 4) begin
                n_chk++;
                if (col0 !== 10'd1) begin
                    n_fail++;
                    $display("FAIL col_after_first_req got %0d exp 1", col0);
                end
            end
            tick();
        end
        n_chk++;
        if (first != C0) begin
            n_fail++;
            $display("FAIL first_req_clk got %0d exp %0d", first, C0);
        end
    endtask

    task automatic test_line();
        int hlow, vis1;
        color_in = 8'hA5;
        release_reset();
        hlow = 0;
        vis1 = 0;
        for (int i = 0; i < 6400; i++) begin
            if (t < 3200 && !hs0) hlow++;
            if (rgb1 === 8'hA5) vis1++;
            n_chk++;
            if (act0 !== expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0)) begin
                n_fail++;
                $display("FAIL line_dut0 t=%0d got %h exp %h", t, act0, expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0));
            end
            n_chk++;
            if (act1 !== expv(t, C1, HT1, VT1, HSS1, VSS1, rgb_m1)) begin
                n_fail++;
                $display("FAIL line_dut1 t=%0d got %h exp %h", t, act1, expv(t, C1, HT1, VT1, HSS1, VSS1, rgb_m1));
            end
            if (t == 799 * C0) begin
                n_chk++;
                if ({col0, row0, ncol0, nrow0} !== {10'd799, 10'd0, 10'd0, 10'd1}) begin
                    n_fail++;
                    $display("FAIL col799_next got col=%0d row=%0d ncol=%0d nrow=%0d exp 799 0 0 1",
                             col0, row0, ncol0, nrow0);
                end
            end
            if (t == 800 * C0) begin
                n_chk++;
                if ({col0, row0} !== {10'd0, 10'd1}) begin
                    n_fail++;
                    $display("FAIL line_wrap got col=%0d row=%0d exp 0 1", col0, row0);
                end
            end
            tick();
        end
        n_chk++;
        if (hlow != 96 * C0) begin
            n_fail++;
            $display("FAIL hsync_low_clks got %0d exp %0d", hlow, 96 * C0);
        end
        // 20 small frames of 10x5 visible pixels, 2 clocks each
        n_chk++;
        if (vis1 != 20 * 50 * C1) begin
            n_fail++;
            $display("FAIL visible_clks_small got %0d exp %0d", vis1, 20 * 50 * C1);
        end
    endtask

    task automatic test_frame();
        int nfs, vlow, hlow;
        logic was_req;
        release_reset();
        nfs = 0; vlow = 0; hlow = 0;
        for (int i = 0; i < 3 * HT1 * VT1 * C1; i++) begin
            if (fs1) nfs++;
            if (!vs1) vlow++;
            if (!hs1) hlow++;
            n_chk++;
            if (act1 !== expv(t, C1, HT1, VT1, HSS1, VSS1, rgb_m1)) begin
                n_fail++;
                $display("FAIL frame_dut1 t=%0d got %h exp %h", t, act1, expv(t, C1, HT1, VT1, HSS1, VSS1, rgb_m1));
            end
            n_chk++;
            if (act0 !== expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0)) begin
                n_fail++;
                $display("FAIL frame_dut0 t=%0d got %h exp %h", t, act0, expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0));
            end
            was_req = req1;
            tick();
            // first two frames: colour changes every clock; third: only right after a pixel boundary
            if (i < 2 * HT1 * VT1 * C1 || was_req) color_in = 8'($urandom);
        end
        n_chk++;
        if (nfs != 3) begin
            n_fail++;
            $display("FAIL frame_start_count got %0d exp 3", nfs);
        end
        n_chk++;
        if (vlow != 3 * 2 * HT1 * C1) begin
            n_fail++;
            $display("FAIL vsync_low_clks got %0d exp %0d", vlow, 3 * 2 * HT1 * C1);
        end
        n_chk++;
        if (hlow != 3 * VT1 * 3 * C1) begin
            n_fail++;
            $display("FAIL hsync_low_clks_small got %0d exp %0d", hlow, 3 * VT1 * 3 * C1);
        end
    endtask

    task automatic test_mid_reset();
        color_in = 8'h3C;
        release_reset();
        // small instance in its vsync rows here
        while (t < 290) tick();
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({col1, row1, hs1, vs1, rgb1, req1} !== {10'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_vsync got col=%0d row=%0d hs=%b vs=%b rgb=%h req=%b exp 0 0 1 1 00 0",
                     col1, row1, hs1, vs1, rgb1, req1);
        end
        release_reset();
        while (t < 300 * C0 + 2) tick();
        n_chk++;
        if (col0 !== 10'd300) begin
            n_fail++;
            $display("FAIL mid_reset_setup got col=%0d exp 300", col0);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({col0, row0, hs0, vs0, rgb0, req0, fs0} !== {10'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_async got col=%0d row=%0d hs=%b vs=%b rgb=%h req=%b fs=%b exp 0 0 1 1 00 0 0",
                     col0, row0, hs0, vs0, rgb0, req0, fs0);
        end
        release_reset();
        for (int i = 0; i < 3300; i++) begin
            n_chk++;
            if (act0 !== expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0)) begin
                n_fail++;
                $display("FAIL restart_dut0 t=%0d got %h exp %h", t, act0, expv(t, C0, HT0, VT0, HSS0, VSS0, rgb_m0));
            end
            n_chk++;
            if (act1 !== expv(t, C1, HT1, VT1, HSS1, VSS1, rgb_m1)) begin
                n_fail++;
                $display("FAIL restart_dut1 t=%0d got %h exp %h", t, act1, expv(t, C1, HT1, VT1, HSS1, VSS1, rgb_m1));
            end
            tick();
            if (i % 7 == 0) color_in = 8'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_first_req();
        reset = 1'b1;
        test_line();
        reset = 1'b1;
        test_frame();
        reset = 1'b1;
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
